// File: rtl/memory_access.sv
// MEM pipeline stage: byte-addressed little-endian data memory with aligned
// byte/halfword/word loads and stores, a MEM/WB register, and a debug word port.
module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_ADDR-3:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [7:0]         mem [DEPTH];
    logic [NB_ADDR-1:0] addr, addr1, addr2, addr3;
    logic [NB_ADDR-1:0] dbg_base;
    logic [31:0]        load_word, dbg_word;
    logic [NB_DATA-1:0] load_ext, read_next;
    logic               misaligned, fault, do_write;

    // upper address bits are dropped so accesses wrap modulo the depth
    assign addr  = i_result[NB_ADDR-1:0];
    assign addr1 = addr + NB_ADDR'(1);
    assign addr2 = addr + NB_ADDR'(2);
    assign addr3 = addr + NB_ADDR'(3);

    assign dbg_base = {i_dbg_addr, 2'b00};

    always_comb begin
        case (i_width)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign fault    = misaligned & (i_memRead | i_memWrite);
    assign do_write = i_memWrite & ~misaligned & ~i_halt & ~i_rst;

    // combinational reads see pre-edge contents, giving read-first behaviour
    assign load_word = {mem[addr3], mem[addr2], mem[addr1], mem[addr]};
    assign dbg_word  = {mem[dbg_base + NB_ADDR'(3)], mem[dbg_base + NB_ADDR'(2)],
                        mem[dbg_base + NB_ADDR'(1)], mem[dbg_base]};

    always_comb begin
        case (i_width)
            2'b00: load_ext = i_sign_flag ? {{(NB_DATA-8){load_word[7]}}, load_word[7:0]}
                                          : {{(NB_DATA-8){1'b0}}, load_word[7:0]};
            2'b01: load_ext = i_sign_flag ? {{(NB_DATA-16){load_word[15]}}, load_word[15:0]}
                                          : {{(NB_DATA-16){1'b0}}, load_word[15:0]};
            default: load_ext = NB_DATA'(load_word);
        endcase
    end

    assign read_next = (i_memRead && !misaligned) ? load_ext : '0;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr] <= i_data4Mem[7:0];
            if (i_width != 2'b00) mem[addr1] <= i_data4Mem[15:8];
            if (i_width[1]) begin
                mem[addr2] <= i_data4Mem[23:16];
                mem[addr3] <= i_data4Mem[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_write_reg  <= '0;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_misaligned <= 1'b0;
            o_dbg_data   <= '0;
        end else begin
            // debug port keeps tracking memory even while the pipeline is halted
            o_dbg_data <= NB_DATA'(dbg_word);
            if (!i_halt) begin
                o_mem2reg    <= i_mem2reg;
                o_regWrite   <= i_regWrite & ~fault;
                o_write_reg  <= i_write_reg;
                o_read_data  <= read_next;
                o_alu_result <= i_result;
                o_misaligned <= fault;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized check of memory_access against a byte-array reference model,
// plus directed scenarios with hand-computed literal expectations.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        i_rst, i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result, i_data4Mem;
    logic [5:0]  i_dbg_addr;
    logic        o_mem2reg, o_regWrite, o_misaligned;
    logic [4:0]  o_write_reg;
    logic [31:0] o_read_data, o_alu_result, o_dbg_data;

    memory_access #(.NB_DATA(32), .NB_ADDR(8)) dut (
        .clk(clk), .i_rst(i_rst), .i_halt(i_halt), .i_mem2reg(i_mem2reg),
        .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
        .i_width(i_width), .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg),
        .i_result(i_result), .i_data4Mem(i_data4Mem), .i_dbg_addr(i_dbg_addr),
        .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite), .o_write_reg(o_write_reg),
        .o_read_data(o_read_data), .o_alu_result(o_alu_result),
        .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  mm [256];
    bit          kn [256];
    logic        e_m2r, e_rw, e_mis;
    logic [4:0]  e_wr;
    logic [31:0] e_rd, e_alu, e_dbg;
    bit          e_rd_ok, e_dbg_ok;
    bit          chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void rd_model(input int a, input int n, input bit sgn,
                                     output logic [31:0] v, output bit ok);
        v  = 0;
        ok = 1;
        for (int k = 0; k < n; k++) begin
            v  = v | (32'(mm[(a + k) % 256]) << (8 * k));
            ok = ok & kn[(a + k) % 256];
        end
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    endfunction

    // predict the post-edge outputs from current inputs, advance one clock, apply stores
    task automatic tick();
        int          a, n;
        bit          mis, flt, wr_now, ok;
        logic [31:0] v;
        logic        n_m2r, n_rw, n_mis;
        logic [4:0]  n_wr;
        logic [31:0] n_rd, n_alu, n_dbg;
        bit          n_rd_ok, n_dbg_ok;
        a   = int'(i_result[7:0]);
        n   = (i_width == 2'b00) ? 1 : (i_width == 2'b01) ? 2 : 4;
        mis = (n == 1) ? 1'b0 : (a % n != 0);
        flt = mis && (i_memRead || i_memWrite);
        {n_m2r, n_rw, n_mis, n_wr, n_rd, n_alu, n_dbg} = {e_m2r, e_rw, e_mis, e_wr, e_rd, e_alu, e_dbg};
        n_rd_ok = e_rd_ok;
        n_dbg_ok = e_dbg_ok;
        wr_now = 0;
        if (i_rst) begin
            {n_m2r, n_rw, n_mis, n_wr, n_rd, n_alu, n_dbg} = '0;
            n_rd_ok = 1;
            n_dbg_ok = 1;
        end else begin
            rd_model(int'(i_dbg_addr) * 4, 4, 0, n_dbg, n_dbg_ok);
            if (!i_halt) begin
                n_m2r = i_mem2reg;
                n_rw  = i_regWrite && !flt;
                n_wr  = i_write_reg;
                n_alu = i_result;
                n_mis = flt;
                if (i_memRead && !mis) begin
                    rd_model(a, n, i_sign_flag, v, ok);
                    n_rd = v;
                    n_rd_ok = ok;
                end else begin
                    n_rd = 0;
                    n_rd_ok = 1;
                end
                wr_now = i_memWrite && !mis;
            end
        end
        @(posedge clk);
        #1;
        {e_m2r, e_rw, e_mis, e_wr, e_rd, e_alu, e_dbg} = {n_m2r, n_rw, n_mis, n_wr, n_rd, n_alu, n_dbg};
        e_rd_ok = n_rd_ok;
        e_dbg_ok = n_dbg_ok;
        if (wr_now)
            for (int k = 0; k < n; k++) begin
                mm[(a + k) % 256] = i_data4Mem[8*k +: 8];
                kn[(a + k) % 256] = 1;
            end
    endtask

    task automatic op(input bit rd, input bit wr, input logic [1:0] w, input bit s,
                      input logic [31:0] ad, input logic [31:0] d);
        i_memRead = rd;
        i_memWrite = wr;
        i_width = w;
        i_sign_flag = s;
        i_result = ad;
        i_data4Mem = d;
        tick();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem2reg", 32'(o_mem2reg), 32'(e_m2r));
            chk("regWrite", 32'(o_regWrite), 32'(e_rw));
            chk("write_reg", 32'(o_write_reg), 32'(e_wr));
            chk("alu_result", o_alu_result, e_alu);
            chk("misaligned", 32'(o_misaligned), 32'(e_mis));
            if (e_rd_ok) chk("read_data", o_read_data, e_rd);
            if (e_dbg_ok) chk("dbg_data", o_dbg_data, e_dbg);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mm[i] = 8'h00;
            kn[i] = 0;
        end
        {e_m2r, e_rw, e_mis, e_wr, e_rd, e_alu, e_dbg} = '0;
        e_rd_ok = 1;
        e_dbg_ok = 1;
        i_rst = 1; i_halt = 0; i_mem2reg = 1; i_regWrite = 1; i_write_reg = 5'd7;
        i_dbg_addr = 6'd3;
        op(1, 1, 2'b11, 0, 32'h0000_0044, 32'hA5A5_A5A5);
        chk_en = 1;
        op(1, 1, 2'b11, 0, 32'h0000_0048, 32'h5A5A_5A5A);
        chk("rst alu_result", o_alu_result, 32'h0);
        chk("rst read_data", o_read_data, 32'h0);
        chk("rst regWrite", 32'(o_regWrite), 32'h0);
        chk("rst dbg_data", o_dbg_data, 32'h0);
        i_rst = 0; i_mem2reg = 0; i_regWrite = 0; i_write_reg = 0;

        // fill memory so every later read has a known expectation
        for (int w = 0; w < 64; w++) op(0, 1, 2'b11, 0, 32'(w * 4), $urandom);

        // little-endian layout and extension
        op(0, 1, 2'b11, 0, 32'h10, 32'h8899AABB);
        op(1, 0, 2'b00, 1, 32'h11, 32'h0);
        chk("lit sbyte@11", o_read_data, 32'hFFFFFFAA);
        op(1, 0, 2'b01, 0, 32'h12, 32'h0);
        chk("lit uhalf@12", o_read_data, 32'h00008899);

        // misaligned word store
        op(0, 1, 2'b11, 0, 32'h04, 32'h01020304);
        i_regWrite = 1;
        op(0, 1, 2'b11, 0, 32'h06, 32'hFFFFFFFF);
        chk("lit misaligned", 32'(o_misaligned), 32'h1);
        chk("lit fault regWrite", 32'(o_regWrite), 32'h0);
        i_regWrite = 0;
        i_dbg_addr = 6'd1;
        op(0, 0, 2'b11, 0, 32'h0, 32'h0);
        chk("lit dbg@04", o_dbg_data, 32'h01020304);

        // read-first on simultaneous read/write
        op(0, 1, 2'b11, 0, 32'h20, 32'hDEADBEEF);
        op(1, 1, 2'b11, 0, 32'h20, 32'h12345678);
        chk("lit rdfirst old", o_read_data, 32'hDEADBEEF);
        op(1, 0, 2'b11, 0, 32'h20, 32'h0);
        chk("lit rdfirst new", o_read_data, 32'h12345678);

        // halt with a pending store
        op(0, 1, 2'b11, 0, 32'h30, 32'h11111111);
        op(1, 0, 2'b11, 0, 32'h10, 32'h0);
        i_halt = 1;
        i_dbg_addr = 6'd4;
        op(0, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D);
        chk("lit halt rd", o_read_data, 32'h8899AABB);
        chk("lit halt dbg4", o_dbg_data, 32'h8899AABB);
        i_dbg_addr = 6'd8;
        op(0, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D);
        chk("lit halt dbg8", o_dbg_data, 32'h12345678);
        i_dbg_addr = 6'd12;
        op(0, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D);
        chk("lit halt dbg12", o_dbg_data, 32'h11111111);
        chk("lit halt alu", o_alu_result, 32'h10);
        i_halt = 0;
        op(1, 0, 2'b11, 0, 32'h30, 32'h0);
        chk("lit halt nowrite", o_read_data, 32'h11111111);

        // reset during a store
        i_rst = 1; i_regWrite = 1; i_mem2reg = 1; i_write_reg = 5'd9;
        op(1, 1, 2'b11, 0, 32'h30, 32'h99999999);
        chk("lit rst rd", o_read_data, 32'h0);
        chk("lit rst wreg", 32'(o_write_reg), 32'h0);
        chk("lit rst m2r", 32'(o_mem2reg), 32'h0);
        i_rst = 0; i_regWrite = 0; i_mem2reg = 0; i_write_reg = 0;
        op(1, 0, 2'b11, 0, 32'h30, 32'h0);
        chk("lit rst nowrite", o_read_data, 32'h11111111);
        op(1, 0, 2'b11, 0, 32'h10, 32'h0);
        chk("lit rst keep", o_read_data, 32'h8899AABB);

        // randomized traffic; upper address bits exercise wrap-around
        for (int c = 0; c < 3000; c++) begin
            i_rst       = ($urandom_range(0, 49) == 0);
            i_halt      = ($urandom_range(0, 9) == 0);
            i_mem2reg   = 1'($urandom);
            i_regWrite  = 1'($urandom);
            i_write_reg = 5'($urandom);
            i_dbg_addr  = 6'($urandom);
            op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        chk_en = 0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
